// File: rtl/clock_timebase_ctrl.sv
`default_nettype none
// ============================================================================
// clock_timebase_ctrl : prescaled tick, 24 h time-of-day counter, set-mode FSM
// Rev 1.0
// ============================================================================
module clock_timebase_ctrl #(
    parameter int PRESCALE_MAX = 99_999_999,
    parameter int CNT_W        = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             btn_mode,
    input  logic             btn_inc,
    output logic             tick,
    output logic [5:0]       sec,
    output logic [5:0]       min,
    output logic [4:0]       hr,
    output logic [1:0]       mode,
    output logic             blink
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(PRESCALE_MAX);

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_HR  = 2'd1,
        MODE_SET_MIN = 2'd2
    } mode_t;

    mode_t            mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic [5:0]       sec_q, sec_d;
    logic [5:0]       min_q, min_d;
    logic [4:0]       hr_q, hr_d;
    logic             blink_q, blink_d;

    always_comb begin
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        sec_d   = sec_q;
        min_d   = min_q;
        hr_d    = hr_q;
        mode_d  = mode_q;
        blink_d = blink_q;

        if (en) begin
            if (cnt_q == c_cnt_max) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (mode_q == MODE_RUN && tick_q) begin
            if (sec_q == 6'd59) begin
                sec_d = 6'd0;
                if (min_q == 6'd59) begin
                    min_d = 6'd0;
                    hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end

        case (mode_q)
            MODE_RUN: begin
                if (btn_mode) begin
                    mode_d  = MODE_SET_HR;
                    blink_d = 1'b1;
                end
            end
            MODE_SET_HR: begin
                if (tick_q) blink_d = ~blink_q;
                if (btn_mode) begin
                    mode_d = MODE_SET_MIN;
                end else if (btn_inc) begin
                    hr_d = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
                end
            end
            MODE_SET_MIN: begin
                if (tick_q) blink_d = ~blink_q;
                if (btn_mode) begin
                    // Restart the timebase so the first RUN second is a full period.
                    mode_d  = MODE_RUN;
                    sec_d   = 6'd0;
                    cnt_d   = '0;
                    tick_d  = 1'b0;
                    blink_d = 1'b0;
                end else if (btn_inc) begin
                    min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                end
            end
            default: begin
                mode_d  = MODE_RUN;
                blink_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            sec_q   <= 6'd0;
            min_q   <= 6'd0;
            hr_q    <= 5'd0;
            mode_q  <= MODE_RUN;
            blink_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hr_q    <= hr_d;
            mode_q  <= mode_d;
            blink_q <= blink_d;
        end
    end

    assign tick  = tick_q;
    assign sec   = sec_q;
    assign min   = min_q;
    assign hr    = hr_q;
    assign mode  = mode_q;
    assign blink = blink_q;

endmodule
`default_nettype wire
